// File: rtl/spy_tdc_pkg.sv
// -----------------------------------------------------------------------------
// spy_tdc_pkg
// Shared types and elaboration-time helpers for the spy-chain TDC sensor.
//   tdcState_t : measurement FSM states
//   cntWidth   : width of one sample count (0..NUM_TAPS inclusive)
//   accWidth   : width of the sample accumulator (never overflows)
//   invMask    : per-tap polarity of the settled chain relative to its input
// -----------------------------------------------------------------------------
package spy_tdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        CAPT,
        SYNC,
        ACC,
        SETTLE,
        DONE
    } tdcState_t;

    // Upper bound on tap count supported by the fixed-width mask function.
    localparam int MAX_TAPS = 1024;

    function automatic int cntWidth(input int numTaps);
        return $clog2(numTaps + 1);
    endfunction

    function automatic int accWidth(input int numTaps, input int avgLog2);
        return $clog2(numTaps + 1) + avgLog2;
    endfunction

    // Tap i sits after (i+1)*tapStride inverters, so it settles to the
    // launch value XOR the parity of that stage count.
    function automatic logic [MAX_TAPS-1:0] invMask(input int numTaps, input int tapStride);
        logic [MAX_TAPS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_TAPS; i++) begin
            if (i < numTaps) begin
                m[i] = (((i + 1) * tapStride) % 2) == 1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/spy_tap_chain.sv
// -----------------------------------------------------------------------------
// spy_stage / spy_tap_chain
// spy_stage     : one inverting delay element.
//   a   in  1  stage input
//   y   out 1  inverted output
// spy_tap_chain : CHAIN_LEN inverting stages driven by the launch flop,
//                 tapped after every TAP_STRIDE stages.
//   launch  in  1         chain input (launch flop output)
//   tap     out NUM_TAPS  tap[i] = output of stage (i+1)*TAP_STRIDE
// Each stage output is its own keep-marked net so synthesis cannot merge
// pairs of inverters and collapse the delay line.
// -----------------------------------------------------------------------------
module spy_stage (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module spy_tap_chain #(
    parameter  int CHAIN_LEN  = 100,
    parameter  int TAP_STRIDE = 4,
    localparam int NUM_TAPS   = CHAIN_LEN / TAP_STRIDE
) (
    input  logic                launch,
    output logic [NUM_TAPS-1:0] tap
);

    for (genvar s = 0; s < CHAIN_LEN; s++) begin : gStage
        (* keep *) logic stageOut;
        if (s == 0) begin : gFirst
            spy_stage uStage (.a(launch), .y(stageOut));
        end else begin : gRest
            spy_stage uStage (.a(gStage[s-1].stageOut), .y(stageOut));
        end
    end

    for (genvar i = 0; i < NUM_TAPS; i++) begin : gTap
        (* keep *) logic tapNet;
        assign tapNet = gStage[(i + 1) * TAP_STRIDE - 1].stageOut;
        assign tap[i] = tapNet;
    end

endmodule

// File: rtl/spy_tdc_sensor.sv
// -----------------------------------------------------------------------------
// spy_tdc_sensor
// Launches a transition into a tapped inverting spy chain, captures the taps
// one clock later (double-flopped), converts them to a stage-count figure and
// aggregates 2^AVG_LOG2 samples into avg/min/max/last plus a saturation flag.
//   clk          in   1      system clock
//   rst_n        in   1      synchronous active-low reset
//   start        in   1      begin a measurement (accepted only in IDLE)
//   abort        in   1      cancel a measurement in progress
//   busy         out  1      high from start acceptance until DONE
//   done         out  1      one-cycle pulse when results update
//   result_avg   out  CNT_W  accumulated counts >> AVG_LOG2 (truncating)
//   result_min   out  CNT_W  smallest sample
//   result_max   out  CNT_W  largest sample
//   result_last  out  CNT_W  final sample
//   saturated    out  1      some sample reached NUM_TAPS
// Handshake: start is a level sampled at a clock edge; it is only acted on in
// IDLE with abort low, and is neither queued nor acknowledged otherwise.
// -----------------------------------------------------------------------------
module spy_tdc_sensor
    import spy_tdc_pkg::*;
#(
    parameter  int CHAIN_LEN  = 100,
    parameter  int TAP_STRIDE = 4,
    parameter  int AVG_LOG2   = 2,
    parameter  int SETTLE_CYC = 8,
    localparam int NUM_TAPS   = CHAIN_LEN / TAP_STRIDE,
    localparam int CNT_W      = cntWidth(NUM_TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result_avg,
    output logic [CNT_W-1:0] result_min,
    output logic [CNT_W-1:0] result_max,
    output logic [CNT_W-1:0] result_last,
    output logic             saturated
);

    localparam int ACC_W  = accWidth(NUM_TAPS, AVG_LOG2);
    localparam int SCNT_W = AVG_LOG2 + 1;
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int N_SAMP = 1 << AVG_LOG2;

    localparam logic [MAX_TAPS-1:0] INV_MASK  = invMask(NUM_TAPS, TAP_STRIDE);
    localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(NUM_TAPS);
    localparam logic [SCNT_W-1:0]   LAST_SAMP = SCNT_W'(N_SAMP - 1);
    localparam logic [SET_W-1:0]    LAST_SET  = SET_W'(SETTLE_CYC - 1);

    tdcState_t           state;
    logic                launchQ;
    logic [NUM_TAPS-1:0] tapVec;
    logic [NUM_TAPS-1:0] tapCap;
    logic [NUM_TAPS-1:0] tapSync;
    logic [NUM_TAPS-1:0] invVec;
    logic [NUM_TAPS-1:0] matchVec;
    logic [CNT_W-1:0]    runCnt;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    minQ;
    logic [CNT_W-1:0]    maxQ;
    logic [CNT_W-1:0]    lastQ;
    logic                satAny;
    logic [SCNT_W-1:0]   sampleCnt;
    logic [SET_W-1:0]    settleCnt;

    spy_tap_chain #(
        .CHAIN_LEN  (CHAIN_LEN),
        .TAP_STRIDE (TAP_STRIDE)
    ) uChain (
        .launch (launchQ),
        .tap    (tapVec)
    );

    assign invVec = INV_MASK[NUM_TAPS-1:0];

    // A tap "matches" once the launched edge has reached it.
    assign matchVec = tapSync ~^ ({NUM_TAPS{launchQ}} ^ invVec);

    // Leading run of matches from tap 0; stray matches past the first miss
    // (bubbles from uneven stage delays) do not count.
    always_comb begin
        logic stillRun;
        runCnt   = '0;
        stillRun = 1'b1;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (stillRun && matchVec[i]) begin
                runCnt = runCnt + 1'b1;
            end else begin
                stillRun = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            launchQ     <= 1'b0;
            tapCap      <= '0;
            tapSync     <= '0;
            acc         <= '0;
            minQ        <= '0;
            maxQ        <= '0;
            lastQ       <= '0;
            satAny      <= 1'b0;
            sampleCnt   <= '0;
            settleCnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_avg  <= '0;
            result_min  <= '0;
            result_max  <= '0;
            result_last <= '0;
            saturated   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                // launchQ is left alone so launch polarity keeps alternating.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state     <= LAUNCH;
                            busy      <= 1'b1;
                            acc       <= '0;
                            minQ      <= '1;
                            maxQ      <= '0;
                            satAny    <= 1'b0;
                            sampleCnt <= '0;
                        end
                    end
                    LAUNCH: begin
                        launchQ <= ~launchQ;
                        state   <= CAPT;
                    end
                    CAPT: begin
                        tapCap <= tapVec;
                        state  <= SYNC;
                    end
                    SYNC: begin
                        tapSync <= tapCap;
                        state   <= ACC;
                    end
                    ACC: begin
                        acc   <= acc + ACC_W'(runCnt);
                        lastQ <= runCnt;
                        if (runCnt < minQ) minQ <= runCnt;
                        if (runCnt > maxQ) maxQ <= runCnt;
                        if (runCnt == FULL_CNT) satAny <= 1'b1;
                        sampleCnt <= sampleCnt + 1'b1;
                        if (sampleCnt == LAST_SAMP) begin
                            state <= DONE;
                        end else begin
                            state     <= SETTLE;
                            settleCnt <= '0;
                        end
                    end
                    SETTLE: begin
                        if (settleCnt == LAST_SET) begin
                            state <= LAUNCH;
                        end else begin
                            settleCnt <= settleCnt + 1'b1;
                        end
                    end
                    DONE: begin
                        result_avg  <= acc[ACC_W-1:AVG_LOG2];
                        result_min  <= minQ;
                        result_max  <= maxQ;
                        result_last <= lastQ;
                        saturated   <= satAny;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spy_tdc_sensor.sv
// -----------------------------------------------------------------------------
// tb_spy_tdc_sensor
// Directed bench for spy_tdc_sensor at default parameters (25 taps, N=4,
// SETTLE_CYC=8). The real chain is zero-delay in simulation (full depth);
// for programmable depth the tap vector inside the DUT is overridden with a
// pattern built from the bench's own model of the launch polarity.
// -----------------------------------------------------------------------------
module tb_spy_tdc_sensor;

    localparam int CHAIN_LEN  = 100;
    localparam int TAP_STRIDE = 4;
    localparam int AVG_LOG2   = 2;
    localparam int SETTLE_CYC = 8;
    localparam int NUM_TAPS   = CHAIN_LEN / TAP_STRIDE;
    localparam int CNT_W      = $clog2(NUM_TAPS + 1);
    localparam int N_SAMP     = 1 << AVG_LOG2;
    localparam int SPACING    = 4 + SETTLE_CYC;
    localparam int LATENCY    = N_SAMP * 4 + (N_SAMP - 1) * SETTLE_CYC + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] result_avg;
    logic [CNT_W-1:0] result_min;
    logic [CNT_W-1:0] result_max;
    logic [CNT_W-1:0] result_last;
    logic             saturated;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ[$];
    logic        lqModel;
    logic [NUM_TAPS-1:0] forcedTaps;

    spy_tdc_sensor #(
        .CHAIN_LEN  (CHAIN_LEN),
        .TAP_STRIDE (TAP_STRIDE),
        .AVG_LOG2   (AVG_LOG2),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .result_avg  (result_avg),
        .result_min  (result_min),
        .result_max  (result_max),
        .result_last (result_last),
        .saturated   (saturated)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tap pattern for a given transition depth: taps the edge has reached
    // show the new settled value, the rest still show the previous one.
    // The bubble pattern matches taps 0,1,2,4,5 only.
    function automatic logic [NUM_TAPS-1:0] mkTaps(input int depth, input logic lqv, input bit bubble);
        logic [NUM_TAPS-1:0] v;
        logic m;
        logic refBit;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (bubble) m = (i == 0 || i == 1 || i == 2 || i == 4 || i == 5);
            else        m = (i < depth);
            refBit = lqv ^ ((((i + 1) * TAP_STRIDE) % 2) == 1);
            v[i] = m ? refBit : ~refBit;
        end
        return v;
    endfunction

    task automatic pushExp(input int avg, input int mn, input int mx, input int last, input int sat);
        expQ.push_back(avg);
        expQ.push_back(mn);
        expQ.push_back(mx);
        expQ.push_back(last);
        expQ.push_back(sat);
    endtask

    task automatic checkResults(input string tag);
        checkVal({tag, "_avg"},  32'(result_avg),  expQ.pop_front());
        checkVal({tag, "_min"},  32'(result_min),  expQ.pop_front());
        checkVal({tag, "_max"},  32'(result_max),  expQ.pop_front());
        checkVal({tag, "_last"}, 32'(result_last), expQ.pop_front());
        checkVal({tag, "_sat"},  32'(saturated),   expQ.pop_front());
    endtask

    // One measurement. Depth patterns are applied right after each sample's
    // launch begins; lat is the cycle count from the accept edge to done
    // (-1 if aborted or the cycle budget expires).
    task automatic measure(input int d0, input int d1, input int d2, input int d3,
                           input bit useForce, input bit bubble, input bit pokeStart,
                           input int abortAt, output int lat);
        int depths[4];
        int k;
        depths[0] = d0; depths[1] = d1; depths[2] = d2; depths[3] = d3;
        k   = 0;
        lat = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkVal("busy_at_accept", 32'(busy), 1);
        for (int c = 0; c < 200; c++) begin
            if ((c % SPACING) == 0 && k < N_SAMP) begin
                lqModel = ~lqModel;
                if (useForce) begin
                    forcedTaps = mkTaps(depths[k], lqModel, bubble);
                    force dut.tapVec = forcedTaps;
                end
                k++;
            end
            if (pokeStart) start = (c == 5);
            abort = (c == abortAt);
            tick();
            start = 1'b0;
            if (c == abortAt) begin
                abort = 1'b0;
                break;
            end
            if (done) begin
                lat = c + 1;
                break;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int doneSeen;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        lqModel = 1'b0;
        forcedTaps = '0;
        repeat (3) tick();

        checkVal("rst_busy", 32'(busy), 0);
        checkVal("rst_done", 32'(done), 0);
        pushExp(0, 0, 0, 0, 0);
        checkResults("rst");
        rst_n = 1'b1;
        tick();

        // Zero-delay chain: every sample is full depth; start poked while busy.
        measure(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, -1, lat);
        checkVal("zero_latency", lat, LATENCY);
        pushExp(25, 25, 25, 25, 1);
        checkResults("zero");
        tick();
        checkVal("done_one_cycle", 32'(done), 0);
        repeat (3) tick();
        checkVal("start_while_busy_ignored", 32'(busy), 0);

        // Programmed depths.
        measure(10, 12, 14, 16, 1'b1, 1'b0, 1'b0, -1, lat);
        checkVal("ramp_latency", lat, LATENCY);
        pushExp(13, 10, 16, 16, 0);
        checkResults("ramp");
        repeat (2) tick();

        // Extremes: empty, full, and truncating average (28/4 = 7).
        measure(0, 25, 1, 2, 1'b1, 1'b0, 1'b0, -1, lat);
        pushExp(7, 0, 25, 2, 1);
        checkResults("edges");
        repeat (2) tick();

        // Bubbles beyond the first miss must not be counted.
        measure(0, 0, 0, 0, 1'b1, 1'b1, 1'b0, -1, lat);
        pushExp(3, 3, 3, 3, 0);
        checkResults("bubble");
        repeat (2) tick();

        // Back-to-back at fixed depth 7.
        measure(7, 7, 7, 7, 1'b1, 1'b0, 1'b0, -1, lat);
        pushExp(7, 7, 7, 7, 0);
        checkResults("b2b_first");
        measure(7, 7, 7, 7, 1'b1, 1'b0, 1'b0, -1, lat);
        checkVal("b2b_latency", lat, LATENCY);
        pushExp(7, 7, 7, 7, 0);
        checkResults("b2b_second");
        repeat (2) tick();

        // Abort during the settle of the second sample (cycle 17 of 12..23).
        measure(9, 9, 9, 9, 1'b1, 1'b0, 1'b0, SPACING + 5, lat);
        checkVal("abort_busy", 32'(busy), 0);
        doneSeen = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) doneSeen++;
            tick();
        end
        checkVal("abort_no_done", doneSeen, 0);
        pushExp(7, 7, 7, 7, 0);
        checkResults("abort_hold");

        // Launch polarity must have continued across the abort.
        measure(5, 6, 7, 8, 1'b1, 1'b0, 1'b0, -1, lat);
        pushExp(6, 5, 8, 8, 0);
        checkResults("post_abort");
        release dut.tapVec;
        repeat (2) tick();

        // start together with abort in IDLE is ignored.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkVal("start_abort_idle", 32'(busy), 0);
        tick();
        checkVal("start_abort_no_done", 32'(done), 0);

        // Reset mid-measurement.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        checkVal("midrst_busy", 32'(busy), 0);
        checkVal("midrst_done", 32'(done), 0);
        pushExp(0, 0, 0, 0, 0);
        checkResults("midrst");
        rst_n   = 1'b1;
        lqModel = 1'b0;
        tick();
        measure(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, -1, lat);
        checkVal("after_rst_latency", lat, LATENCY);
        pushExp(25, 25, 25, 25, 1);
        checkResults("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
